// File: rtl/elevator_dispatch.sv
// Single-car request scheduler: merges car/hall requests, picks SCAN targets,
// hands them to the motion block and times the door dwell. Optional door hold: DOOR_HOLD_EN.
module elevator_dispatch #(
  parameter int NUM_FLOORS   = 8,
  parameter int FLOOR_W      = 3,
  parameter int DWELL_CYCLES = 16,
  parameter int DWELL_W      = 5
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [NUM_FLOORS-1:0] i_car_req,
  input  logic [NUM_FLOORS-1:0] i_hall_req,
  input  logic [FLOOR_W-1:0]    i_car_floor,
  input  logic                  i_car_arrived,
  input  logic                  i_target_ready,
`ifdef DOOR_HOLD_EN
  input  logic                  i_door_hold,
`endif
  output logic [FLOOR_W-1:0]    o_target_floor,
  output logic                  o_target_valid,
  output logic                  o_door_open,
  output logic                  o_dir_down,
  output logic [NUM_FLOORS-1:0] o_pending,
  output logic [1:0]            o_state
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DISPATCH = 2'd1,
    ST_MOVING   = 2'd2,
    ST_DOOR     = 2'd3
  } state_t;

  localparam logic [DWELL_W-1:0] DWELL_LOAD = DWELL_W'(DWELL_CYCLES - 1);

  state_t                r_state;
  logic [NUM_FLOORS-1:0] r_pending;
  logic [FLOOR_W-1:0]    r_target;
  logic                  r_valid;
  logic                  r_door_open;
  logic                  r_dir_down;
  logic [DWELL_W-1:0]    r_dwell;

  logic [NUM_FLOORS-1:0] w_req;
  logic [NUM_FLOORS-1:0] w_floor_mask;
  logic [NUM_FLOORS-1:0] w_set;
  logic [NUM_FLOORS-1:0] w_clr;
  logic                  w_above_any;
  logic                  w_below_any;
  logic [FLOOR_W-1:0]    w_lowest_above;
  logic [FLOOR_W-1:0]    w_highest_below;
  logic [FLOOR_W-1:0]    w_sel_floor;
  logic                  w_sel_dir;
  logic                  w_idle_hit;
  logic                  w_arrive_hit;
  logic                  w_hold;
  logic                  w_door_reload;

  assign w_req        = i_car_req | i_hall_req;
  assign w_floor_mask = NUM_FLOORS'(1) << i_car_floor;
  assign w_idle_hit   = r_pending[i_car_floor];
  assign w_arrive_hit = i_car_arrived && (i_car_floor == r_target);

`ifdef DOOR_HOLD_EN
  assign w_hold = i_door_hold;
`else
  assign w_hold = 1'b0;
`endif

  // Nearest pending floor above and below the car, then SCAN choice.
  always_comb begin
    w_above_any     = 1'b0;
    w_below_any     = 1'b0;
    w_lowest_above  = '0;
    w_highest_below = '0;
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      w_lowest_above = (r_pending[i] && (FLOOR_W'(i) > i_car_floor)) ? FLOOR_W'(i) : w_lowest_above;
      w_above_any    = w_above_any | (r_pending[i] && (FLOOR_W'(i) > i_car_floor));
    end
    for (int i = 0; i < NUM_FLOORS; i++) begin
      w_highest_below = (r_pending[i] && (FLOOR_W'(i) < i_car_floor)) ? FLOOR_W'(i) : w_highest_below;
      w_below_any     = w_below_any | (r_pending[i] && (FLOOR_W'(i) < i_car_floor));
    end
    w_sel_floor = i_car_floor;
    w_sel_dir   = r_dir_down;
    if (!r_dir_down) begin
      if (w_above_any) begin
        w_sel_floor = w_lowest_above;
        w_sel_dir   = 1'b0;
      end else if (w_below_any) begin
        w_sel_floor = w_highest_below;
        w_sel_dir   = 1'b1;
      end else begin
        w_sel_floor = i_car_floor;
        w_sel_dir   = r_dir_down;
      end
    end else begin
      if (w_below_any) begin
        w_sel_floor = w_highest_below;
        w_sel_dir   = 1'b1;
      end else if (w_above_any) begin
        w_sel_floor = w_lowest_above;
        w_sel_dir   = 1'b0;
      end else begin
        w_sel_floor = i_car_floor;
        w_sel_dir   = r_dir_down;
      end
    end
  end

  // Pending set/clear masks; a request for the open-door floor is swallowed and restarts the dwell.
  always_comb begin
    w_set         = w_req;
    w_clr         = '0;
    w_door_reload = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_idle_hit) begin
          w_clr = w_floor_mask;
        end else begin
          w_clr = '0;
        end
      end
      ST_MOVING: begin
        if (w_arrive_hit) begin
          w_clr = NUM_FLOORS'(1) << r_target;
        end else begin
          w_clr = '0;
        end
      end
      ST_DOOR: begin
        w_set         = w_req & ~w_floor_mask;
        w_door_reload = (|(w_req & w_floor_mask)) | w_hold;
      end
      default: begin
        w_set = w_req;
      end
    endcase
  end

  // Dispatch FSM with registered outputs and pending bitmap.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_pending   <= '0;
      r_target    <= '0;
      r_valid     <= 1'b0;
      r_door_open <= 1'b0;
      r_dir_down  <= 1'b0;
      r_dwell     <= '0;
    end else begin
      r_pending <= (r_pending | w_set) & ~w_clr;
      case (r_state)
        ST_IDLE: begin
          if (w_idle_hit) begin
            r_state     <= ST_DOOR;
            r_door_open <= 1'b1;
            r_dwell     <= DWELL_LOAD;
          end else if (|r_pending) begin
            r_state    <= ST_DISPATCH;
            r_target   <= w_sel_floor;
            r_dir_down <= w_sel_dir;
            r_valid    <= 1'b1;
          end
        end
        ST_DISPATCH: begin
          if (i_target_ready) begin
            r_state <= ST_MOVING;
            r_valid <= 1'b0;
          end
        end
        ST_MOVING: begin
          if (w_arrive_hit) begin
            r_state     <= ST_DOOR;
            r_door_open <= 1'b1;
            r_dwell     <= DWELL_LOAD;
          end
        end
        ST_DOOR: begin
          if (w_door_reload) begin
            r_dwell <= DWELL_LOAD;
          end else if (r_dwell == '0) begin
            r_state     <= ST_IDLE;
            r_door_open <= 1'b0;
          end else begin
            r_dwell <= r_dwell - DWELL_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_target_floor = r_target;
  assign o_target_valid = r_valid;
  assign o_door_open    = r_door_open;
  assign o_dir_down     = r_dir_down;
  assign o_pending      = r_pending;
  assign o_state        = r_state;

endmodule
